// File: rtl/bpred_pkg.sv
// Shared types and the 2-bit saturating-counter update rule for the branch predictor PHT.
package bpred_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t ST_SNT = 2'b00;
    localparam ctr_t ST_WNT = 2'b01;
    localparam ctr_t ST_WT  = 2'b10;
    localparam ctr_t ST_ST  = 2'b11;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        UPD_WR = 2'd2
    } fsm_t;

    // Correct predictions saturate to the strong state; wrong ones step toward the other side.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        if (ctr[1] == taken) begin
            nxt = ctr[1] ? ST_ST : ST_SNT;
        end else begin
            case (ctr)
                ST_ST:   nxt = ST_WT;
                ST_WT:   nxt = ST_WNT;
                ST_WNT:  nxt = ST_WT;
                default: nxt = ST_WNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Synchronous FIFO holding resolved-branch updates as {index, taken}.
module bpred_upd_fifo #(
    parameter int unsigned DW    = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/bpred_table_ctrl.sv
// PHT sequencer: reset sweep, lookups with priority, queued read-modify-write updates.
// Optional BPRED_STATS_EN adds lookup / misprediction counters.
module bpred_table_ctrl
    import bpred_pkg::*;
#(
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned UQ_DEPTH   = 4,
    parameter ctr_t        INIT_STATE = 2'b11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    input  logic [31:0]      lookup_pc_i,
    output logic             lookup_ready_o,
    output logic             predict_valid_o,
    output logic             predict_taken_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             init_busy_o,
    output logic             tbl_en_o,
    output logic             tbl_we_o,
    output logic [IDX_W-1:0] tbl_addr_o,
    output logic [1:0]       tbl_wdata_o,
    input  logic [1:0]       tbl_rdata_i
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]      stat_lookups_o,
    output logic [31:0]      stat_mispred_o
`endif
);

    localparam int unsigned QW = IDX_W + 1;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    fsm_t             state;
    logic [IDX_W-1:0] init_addr;
    logic             init_wr;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             taken_hold;

    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [QW-1:0]    q_wdata;
    logic [QW-1:0]    q_rdata;

    logic             issue_lkp;
    logic             issue_upd;
    logic [IDX_W-1:0] lkp_idx;
    logic             unused_pc_bits;

    assign lkp_idx        = lookup_pc_i[IDX_W+1:2];
    assign q_wdata        = {upd_pc_i[IDX_W+1:2], upd_taken_i};
    assign q_push         = upd_valid_i & ~q_full;
    assign upd_ready_o    = ~q_full;
    assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                              upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    // A full queue pre-empts lookups so EX never stalls indefinitely.
    assign lookup_ready_o = (state == IDLE) & ~q_full;
    assign issue_lkp      = lookup_ready_o & lookup_valid_i;
    assign issue_upd      = (state == IDLE) & ~q_empty & (q_full | ~lookup_valid_i);
    assign q_pop          = issue_upd;

    assign predict_taken_o = predict_valid_o ? tbl_rdata_i[1] : taken_hold;

    bpred_upd_fifo #(
        .DW    (QW),
        .DEPTH (UQ_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    // Sweep writes are registered so the port stays idle while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= INIT;
            init_addr       <= '0;
            init_wr         <= 1'b0;
            init_busy_o     <= 1'b1;
            predict_valid_o <= 1'b0;
            taken_hold      <= 1'b0;
            upd_idx         <= '0;
            upd_taken       <= 1'b0;
`ifdef BPRED_STATS_EN
            stat_lookups_o  <= '0;
            stat_mispred_o  <= '0;
`endif
        end else begin
            predict_valid_o <= issue_lkp;
            if (predict_valid_o) taken_hold <= tbl_rdata_i[1];
`ifdef BPRED_STATS_EN
            if (issue_lkp) stat_lookups_o <= stat_lookups_o + 32'd1;
            if (state == UPD_WR && tbl_rdata_i[1] != upd_taken)
                stat_mispred_o <= stat_mispred_o + 32'd1;
`endif
            case (state)
                INIT: begin
                    if (!init_wr) begin
                        init_wr <= 1'b1;
                    end else if (init_addr == IDX_MAX) begin
                        init_wr     <= 1'b0;
                        init_addr   <= '0;
                        init_busy_o <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                IDLE: begin
                    if (issue_upd) begin
                        upd_idx   <= q_rdata[QW-1:1];
                        upd_taken <= q_rdata[0];
                        state     <= UPD_WR;
                    end
                end
                UPD_WR:  state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

    // Table port: the read issue must be same-cycle with acceptance to meet 1-cycle latency.
    always_comb begin
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_addr_o  = '0;
        tbl_wdata_o = ST_SNT;
        case (state)
            INIT: begin
                tbl_en_o    = init_wr;
                tbl_we_o    = init_wr;
                tbl_addr_o  = init_addr;
                tbl_wdata_o = init_wr ? INIT_STATE : ST_SNT;
            end
            IDLE: begin
                if (issue_upd) begin
                    tbl_en_o   = 1'b1;
                    tbl_addr_o = q_rdata[QW-1:1];
                end else if (issue_lkp) begin
                    tbl_en_o   = 1'b1;
                    tbl_addr_o = lkp_idx;
                end
            end
            UPD_WR: begin
                tbl_en_o    = 1'b1;
                tbl_we_o    = 1'b1;
                tbl_addr_o  = upd_idx;
                tbl_wdata_o = ctr_next(tbl_rdata_i, upd_taken);
            end
            default: ;
        endcase
    end

endmodule
